// File: rtl/divider_pkg.sv
// divider_pkg
// Shared definitions for the divider pattern sequencer: pattern codes,
// init frames, pattern periods, the bounce/bar direction type and the
// sequencer state type. No ports.

package divider_pkg;

   localparam logic [2:0] PAT_OFF    = 3'd0;
   localparam logic [2:0] PAT_BLINK  = 3'd1;
   localparam logic [2:0] PAT_CHASE  = 3'd2;
   localparam logic [2:0] PAT_BOUNCE = 3'd3;
   localparam logic [2:0] PAT_COUNT  = 3'd4;
   localparam logic [2:0] PAT_BAR    = 3'd5;

   localparam logic [7:0] INIT_OFF    = 8'h00;
   localparam logic [7:0] INIT_BLINK  = 8'h00;
   localparam logic [7:0] INIT_CHASE  = 8'h01;
   localparam logic [7:0] INIT_BOUNCE = 8'h01;
   localparam logic [7:0] INIT_COUNT  = 8'h00;
   localparam logic [7:0] INIT_BAR    = 8'h00;

   localparam int BOUNCE_PERIOD = 14;
   localparam int BAR_PERIOD    = 16;

   // Bounce: up = toward 0x80. Bar: up = fill phase, down = drain phase.
   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   typedef enum logic {
      ST_OFF = 1'b0,
      ST_RUN = 1'b1
   } seq_state_t;

   // Codes 6 and 7 are treated like PAT_OFF.
   function automatic logic pattern_runs(input logic [2:0] pat);
      return (pat >= PAT_BLINK) && (pat <= PAT_BAR);
   endfunction

   function automatic logic [7:0] init_frame(input logic [2:0] pat);
      logic [7:0] f;
      case (pat)
         PAT_BLINK:  f = INIT_BLINK;
         PAT_CHASE:  f = INIT_CHASE;
         PAT_BOUNCE: f = INIT_BOUNCE;
         PAT_COUNT:  f = INIT_COUNT;
         PAT_BAR:    f = INIT_BAR;
         default:    f = INIT_OFF;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/divider_pattern_sequencer_tick_edge_detect.sv
// tick_edge_detect
// Selects one divider tap and produces a one-cycle rising-edge pulse.
// A change of clk_sel suppresses the edge for that cycle so that switching
// to a tap that is already high does not fake a tick.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   taps       : divider outputs, taps[0] fastest
//   clk_sel    : index of the tap to follow
//   tick       : combinational rising-edge pulse of taps[clk_sel]

module tick_edge_detect #(
   parameter int NUM_TAPS = 8,
   parameter int SEL_W    = $clog2(NUM_TAPS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_TAPS-1:0] taps,
   input  logic [SEL_W-1:0]    clk_sel,
   output logic                tick
);

   logic             tap_now;
   logic             tap_q;
   logic [SEL_W-1:0] clk_sel_q;

   assign tap_now = taps[clk_sel];

   // Both registers always track, regardless of enable, so that the first
   // cycle after re-enable or reselection compares against a fresh history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tap_q     <= 1'b0;
         clk_sel_q <= '0;
      end else begin
         tap_q     <= tap_now;
         clk_sel_q <= clk_sel;
      end
   end

   assign tick = tap_now & ~tap_q & (clk_sel == clk_sel_q);

endmodule

// File: rtl/divider_pattern_sequencer.sv
// divider_pattern_sequencer
// Steps an LED pattern on rising edges of a selected clock-divider tap.
// In the chip top, leds drive uo_out, clk_sel = ui_in[2:0] and
// pattern_sel = ui_in[5:3].
// Ports:
//   clk, rst_n  : system clock, async active-low reset
//   ena         : design enable; low blanks the LEDs and freezes the frame
//   taps        : divider outputs, taps[0] fastest
//   clk_sel     : tap used as step tick
//   pattern_sel : 0 off, 1 blink, 2 chaser, 3 bounce, 4 counter, 5 bar
//   leds        : registered LED frame
//   step        : registered one-cycle pulse per frame advance
//
// state  | meaning
// ST_OFF | pattern 0/6/7 selected, frame held at 0x00, no steps
// ST_RUN | pattern 1..5 selected, frame advances on each tick

module divider_pattern_sequencer
   import divider_pkg::*;
#(
   parameter int NUM_TAPS = 8,
   parameter int SEL_W    = $clog2(NUM_TAPS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic [NUM_TAPS-1:0] taps,
   input  logic [SEL_W-1:0]    clk_sel,
   input  logic [2:0]          pattern_sel,
   output logic [7:0]          leds,
   output logic                step
);

   seq_state_t state, state_d;
   logic [2:0] pattern_q, pattern_d;
   logic [7:0] frame, frame_d, frame_adv;
   dir_t       dir, dir_d, dir_adv;
   logic [7:0] leds_d;
   logic       step_d;
   logic       tick;

   tick_edge_detect #(
      .NUM_TAPS (NUM_TAPS),
      .SEL_W    (SEL_W)
   ) u_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .taps    (taps),
      .clk_sel (clk_sel),
      .tick    (tick)
   );

   // Next frame for the active pattern, used only on a tick in ST_RUN.
   always_comb begin
      frame_adv = frame;
      dir_adv   = dir;
      case (pattern_q)
         PAT_BLINK: frame_adv = ~frame;
         PAT_CHASE: frame_adv = {frame[6:0], frame[7]};
         PAT_BOUNCE: begin
            if (dir == DIR_UP) begin
               if (frame == 8'h80) begin
                  frame_adv = 8'h40;
                  dir_adv   = DIR_DOWN;
               end else begin
                  frame_adv = frame << 1;
               end
            end else begin
               if (frame == 8'h01) begin
                  frame_adv = 8'h02;
                  dir_adv   = DIR_UP;
               end else begin
                  frame_adv = frame >> 1;
               end
            end
         end
         PAT_COUNT: frame_adv = frame + 8'd1;
         PAT_BAR: begin
            if (dir == DIR_UP) begin
               if (frame == 8'hFF) begin
                  frame_adv = 8'hFE;
                  dir_adv   = DIR_DOWN;
               end else begin
                  frame_adv = {frame[6:0], 1'b1};
               end
            end else begin
               // Draining 0x80 empties the bar; refill starts next tick.
               frame_adv = {frame[6:0], 1'b0};
               if (frame == 8'h80) begin
                  dir_adv = DIR_UP;
               end
            end
         end
         default: frame_adv = frame;
      endcase
   end

   always_comb begin
      state_d   = state;
      pattern_d = pattern_q;
      frame_d   = frame;
      dir_d     = dir;
      step_d    = 1'b0;
      if (ena) begin
         // A pattern change wins over a coincident tick.
         if (pattern_sel != pattern_q) begin
            pattern_d = pattern_sel;
            frame_d   = init_frame(pattern_sel);
            dir_d     = DIR_UP;
            state_d   = pattern_runs(pattern_sel) ? ST_RUN : ST_OFF;
         end else if ((state == ST_RUN) && tick) begin
            frame_d = frame_adv;
            dir_d   = dir_adv;
            step_d  = 1'b1;
         end
      end
      leds_d = ena ? frame_d : 8'h00;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_OFF;
         pattern_q <= PAT_OFF;
         frame     <= 8'h00;
         dir       <= DIR_UP;
         leds      <= 8'h00;
         step      <= 1'b0;
      end else begin
         state     <= state_d;
         pattern_q <= pattern_d;
         frame     <= frame_d;
         dir       <= dir_d;
         leds      <= leds_d;
         step      <= step_d;
      end
   end

endmodule

// File: tb/tb_divider_pattern_sequencer.sv
module tb_divider_pattern_sequencer;
   import divider_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic [7:0] taps = 8'h00;
   logic [2:0] clk_sel = 3'd0;
   logic [2:0] pattern_sel = 3'd0;
   logic [7:0] leds;
   logic       step;

   always #5 clk = ~clk;

   divider_pattern_sequencer #(.NUM_TAPS(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .taps        (taps),
      .clk_sel     (clk_sel),
      .pattern_sel (pattern_sel),
      .leds        (leds),
      .step        (step)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a pattern is a position within its period, and the
   // frame is computed from that position arithmetically.
   bit         m_tap_q;
   logic [2:0] m_sel_q;
   logic [2:0] m_pat;
   int         m_pos;
   logic [7:0] exp_leds;
   bit         exp_step;
   logic [7:0] div_cnt;

   task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%02h expected 0x%02h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int period_of(input logic [2:0] p);
      case (p)
         PAT_BLINK:  return 2;
         PAT_CHASE:  return 8;
         PAT_BOUNCE: return BOUNCE_PERIOD;
         PAT_COUNT:  return 256;
         PAT_BAR:    return BAR_PERIOD;
         default:    return 1;
      endcase
   endfunction

   function automatic logic [7:0] frame_of(input logic [2:0] p, input int pos);
      int v;
      case (p)
         PAT_BLINK:  v = (pos % 2 == 1) ? 255 : 0;
         PAT_CHASE:  v = 1 << pos;
         PAT_BOUNCE: v = (pos <= 7) ? (1 << pos) : (1 << (14 - pos));
         PAT_COUNT:  v = pos;
         PAT_BAR:    v = (pos <= 8) ? ((1 << pos) - 1) : ((255 << (pos - 8)) & 255);
         default:    v = 0;
      endcase
      return 8'(v);
   endfunction

   task automatic model_reset();
      m_tap_q  = 1'b0;
      m_sel_q  = 3'd0;
      m_pat    = 3'd0;
      m_pos    = 0;
      exp_leds = 8'h00;
      exp_step = 1'b0;
   endtask

   // Inputs are already driven (away from the clock edge); advance the
   // model by one clock, then compare just after the edge.
   task automatic tick();
      bit rise;
      rise = taps[clk_sel] && !m_tap_q && (clk_sel == m_sel_q);
      m_tap_q = taps[clk_sel];
      m_sel_q = clk_sel;
      exp_step = 1'b0;
      if (ena) begin
         if (pattern_sel != m_pat) begin
            m_pat = pattern_sel;
            m_pos = 0;
         end else if (rise && m_pat >= 3'd1 && m_pat <= 3'd5) begin
            m_pos = (m_pos + 1) % period_of(m_pat);
            exp_step = 1'b1;
         end
         exp_leds = frame_of(m_pat, m_pos);
      end else begin
         exp_leds = 8'h00;
      end
      @(posedge clk);
      #1;
      check_eq("leds", leds, exp_leds);
      check_eq("step", {7'b0, step}, {7'b0, exp_step});
   endtask

   task automatic div_tick();
      div_cnt = div_cnt + 8'd1;
      taps = div_cnt;
      tick();
   endtask

   initial begin
      int         cnt;
      int         steps;
      logic [7:0] prev;

      model_reset();
      div_cnt = 8'h00;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_leds", leds, 8'h00);
      check_eq("rst_step", {7'b0, step}, 8'h00);
      rst_n = 1'b1;

      // OFF: steps never happen
      ena = 1'b1;
      repeat (6) div_tick();

      // Chaser on taps[0]
      pattern_sel = PAT_CHASE;
      clk_sel = 3'd0;
      div_tick();
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         div_tick();
         if (step) cnt++;
      end
      check_eq("chase_steps", 8'(cnt), 8'd8);

      // Bounce period and turnaround
      pattern_sel = PAT_BOUNCE;
      div_tick();
      prev = leds;
      steps = 0;
      for (int i = 0; i < 100; i++) begin
         div_tick();
         if (step) begin
            if (prev == 8'h80) check_eq("bounce_after_80", leds, 8'h40);
            prev = leds;
            steps++;
            if (leds == 8'h01) break;
         end
      end
      check_eq("bounce_period", 8'(steps), 8'(BOUNCE_PERIOD));

      // Bar period and phase boundaries
      pattern_sel = PAT_BAR;
      div_tick();
      prev = leds;
      steps = 0;
      for (int i = 0; i < 100; i++) begin
         div_tick();
         if (step) begin
            if (prev == 8'hFF) check_eq("bar_after_ff", leds, 8'hFE);
            if (prev == 8'h80) check_eq("bar_after_80", leds, 8'h00);
            prev = leds;
            steps++;
            if (leds == 8'h00) break;
         end
      end
      check_eq("bar_period", 8'(steps), 8'(BAR_PERIOD));

      // clk_sel change onto a tap that is already high
      pattern_sel = PAT_CHASE;
      clk_sel = 3'd0;
      taps = 8'h00;
      tick();
      tick();
      taps = 8'h08;
      clk_sel = 3'd3;
      tick();
      check_eq("sel_chg_step", {7'b0, step}, 8'h00);
      check_eq("sel_chg_leds", leds, 8'h01);
      taps = 8'h00;
      tick();
      taps = 8'h08;
      tick();

      // Pattern change coincident with an edge
      clk_sel = 3'd0;
      taps = 8'h00;
      tick();
      taps = 8'h01;
      pattern_sel = PAT_COUNT;
      tick();
      check_eq("pat_edge_leds", leds, 8'h00);
      check_eq("pat_edge_step", {7'b0, step}, 8'h00);

      // Enable hold and resume
      for (int i = 0; i < 40 && !(m_pat == PAT_COUNT && m_pos == 5); i++) begin
         taps[0] = ~taps[0];
         tick();
      end
      check_eq("ena_setup", leds, 8'h05);
      ena = 1'b0;
      repeat (40) begin
         taps[0] = ~taps[0];
         tick();
      end
      ena = 1'b1;
      taps = 8'h00;
      tick();
      check_eq("ena_resume", leds, 8'h05);
      taps = 8'h01;
      tick();
      check_eq("ena_next", leds, 8'h06);

      // Randomized operation
      div_cnt = 8'h00;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) pattern_sel = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 59) == 0) clk_sel = 3'($urandom_range(0, 7));
         ena = ($urandom_range(0, 15) != 0);
         div_cnt = div_cnt + 8'd1;
         taps = ($urandom_range(0, 7) == 0) ? 8'($urandom) : div_cnt;
         tick();
      end

      // Asynchronous reset mid-run
      ena = 1'b1;
      clk_sel = 3'd0;
      pattern_sel = PAT_OFF;
      tick();
      pattern_sel = PAT_CHASE;
      tick();
      for (int i = 0; i < 40 && !(m_pat == PAT_CHASE && m_pos == 4); i++) begin
         taps[0] = ~taps[0];
         tick();
      end
      check_eq("rst_setup", leds, 8'h10);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("rst_async_leds", leds, 8'h00);
      check_eq("rst_async_step", {7'b0, step}, 8'h00);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      pattern_sel = PAT_OFF;
      repeat (4) begin
         taps[0] = ~taps[0];
         tick();
      end
      pattern_sel = PAT_BLINK;
      repeat (8) begin
         taps[0] = ~taps[0];
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
